// File: rtl/multi_tick_counter_pkg.sv
// Shared types for the multi-channel tick counter.
// Overflow mode encodings, snapshot state and the snapshot accept rule.
package multi_tick_counter_pkg;

    localparam logic SAT_MODE  = 1'b1;
    localparam logic WRAP_MODE = 1'b0;

    typedef enum logic {
        SNAP_EMPTY = 1'b0,
        SNAP_FULL  = 1'b1
    } snap_state_e;

    function automatic logic snap_accept(
        input logic req,
        input logic full,
        input logic ack
    );
        return req & (~full | ack);
    endfunction

endpackage

// File: rtl/multi_tick_counter_if.sv
// Link between snapshot control and one tick channel.
// master drives the controls, slave returns flags and shadow contents.
interface multi_tick_counter_if #(
    parameter int N = 8
);
    logic         tick;
    logic         clr;
    logic         sat_mode;
    logic         take;
    logic         of;
    logic [N-1:0] sh_cnt;
    logic         sh_of;

    modport master (
        output tick, clr, sat_mode, take,
        input  of, sh_cnt, sh_of
    );

    modport slave (
        input  tick, clr, sat_mode, take,
        output of, sh_cnt, sh_of
    );
endinterface

// File: rtl/tick_channel.sv
// One live counter with its sticky overflow flag and shadow copy.
// A snapshot moves the post-tick value into the shadow and restarts live state.
module tick_channel
    import multi_tick_counter_pkg::*;
#(
    parameter int N = 8
) (
    input logic                 clk,
    input logic                 reset_n,
    multi_tick_counter_if.slave ch
);

    localparam logic [N-1:0] MAXV = '1;

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;
    logic [N-1:0] sh_cnt_q;
    logic [N-1:0] sh_cnt_d;
    logic [N-1:0] post_cnt;
    logic         of_q;
    logic         of_d;
    logic         sh_of_q;
    logic         sh_of_d;
    logic         post_of;
    logic         ev;

    always_comb begin
        post_cnt = cnt_q;
        ev       = 1'b0;
        if (ch.tick) begin
            if (cnt_q == MAXV) begin
                ev = 1'b1;
                unique case (ch.sat_mode)
                    SAT_MODE:  post_cnt = MAXV;
                    WRAP_MODE: post_cnt = '0;
                    default:   post_cnt = '0;
                endcase
            end else begin
                post_cnt = cnt_q + 1'b1;
            end
        end
        post_of = of_q | ev;
    end

    // clr beats both the tick and the snapshot capture
    always_comb begin
        cnt_d    = post_cnt;
        of_d     = post_of;
        sh_cnt_d = sh_cnt_q;
        sh_of_d  = sh_of_q;
        if (ch.clr || ch.take) begin
            cnt_d = '0;
            of_d  = 1'b0;
        end
        if (ch.take) begin
            sh_cnt_d = ch.clr ? '0 : post_cnt;
            sh_of_d  = ~ch.clr & post_of;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            of_q     <= 1'b0;
            sh_cnt_q <= '0;
            sh_of_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            of_q     <= of_d;
            sh_cnt_q <= sh_cnt_d;
            sh_of_q  <= sh_of_d;
        end
    end

    assign ch.of     = of_q;
    assign ch.sh_cnt = sh_cnt_q;
    assign ch.sh_of  = sh_of_q;

endmodule

// File: rtl/multi_tick_counter.sv
// C tick counters with a one-deep snapshot handshake and registered read mux.
// A new snapshot is taken only when the previous one is free or being acked.
module multi_tick_counter
    import multi_tick_counter_pkg::*;
#(
    parameter int N     = 8,
    parameter int C     = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [C-1:0]     tick,
    input  logic             sat_mode,
    input  logic [C-1:0]     clr,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic             snap_valid,
    output logic             snap_drop,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [N-1:0]     rd_count,
    output logic             rd_of,
    output logic [C-1:0]     live_of
);

    snap_state_e  state_q;
    snap_state_e  state_d;
    logic         accept;
    logic         drop_q;
    logic [N-1:0] sh_cnt [C];
    logic [C-1:0] sh_of;
    logic [N-1:0] rd_count_q;
    logic [N-1:0] rd_count_d;
    logic         rd_of_q;
    logic         rd_of_d;

    assign accept = snap_accept(snap_req, state_q == SNAP_FULL, snap_ack);

    for (genvar i = 0; i < C; i++) begin : g_ch
        multi_tick_counter_if #(.N(N)) ch ();

        assign ch.tick     = tick[i];
        assign ch.clr      = clr[i];
        assign ch.sat_mode = sat_mode;
        assign ch.take     = accept;
        assign sh_cnt[i]   = ch.sh_cnt;
        assign sh_of[i]    = ch.sh_of;
        assign live_of[i]  = ch.of;

        tick_channel #(.N(N)) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .ch      (ch)
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SNAP_EMPTY;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= snap_req & ~accept;
        end
    end

    // an accept with ack re-fills, so accept is tested first
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = SNAP_FULL;
        end else if (snap_ack) begin
            state_d = SNAP_EMPTY;
        end
    end

    always_comb begin
        snap_valid = (state_q == SNAP_FULL);
        snap_drop  = drop_q;
    end

    always_comb begin
        rd_count_d = '0;
        rd_of_d    = 1'b0;
        for (int i = 0; i < C; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_count_d = sh_cnt[i];
                rd_of_d    = sh_of[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_count_q <= '0;
            rd_of_q    <= 1'b0;
        end else begin
            rd_count_q <= rd_count_d;
            rd_of_q    <= rd_of_d;
        end
    end

    assign rd_count = rd_count_q;
    assign rd_of    = rd_of_q;

endmodule

// File: doc/multi_tick_counter.md
MULTI_TICK_COUNTER -- requirements
Module: multi_tick_counter

Interface
REQ-001 Parameter N, default 8: counter width per channel in bits, N >= 2.
REQ-002 Parameter C, default 4: number of channels, C >= 1.
REQ-003 Parameter SEL_W, default 2: read-select width, SEL_W = max(1, ceil(log2(C))).
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 tick  in  C  per-channel tick; bit i is sampled every clk and counted when high.
REQ-007 sat_mode  in  1  overflow mode: 1 = saturate at 2^N-1, 0 = wrap to 0.
REQ-008 clr  in  C  per-channel synchronous clear of the live counter and the overflow flag.
REQ-009 snap_req  in  1  single-cycle request to capture all channels into shadow registers.
REQ-010 snap_ack  in  1  consumer release of the current snapshot.
REQ-011 snap_valid  out  1  high while the shadow registers hold an unacknowledged snapshot.
REQ-012 snap_drop  out  1  one-cycle pulse when snap_req is rejected.
REQ-013 rd_sel  in  SEL_W  shadow channel select.
REQ-014 rd_count  out  N  shadow count of channel rd_sel, registered.
REQ-015 rd_of  out  1  shadow overflow flag of channel rd_sel, registered.
REQ-016 live_of  out  C  live sticky overflow flags.

Function
REQ-017 Live counter i SHALL load cnt+1 on a cycle with tick[i]=1, and hold otherwise.
REQ-018 Wrap mode, cnt = 2^N-1 with tick: counter SHALL go to 0 and of[i] SHALL be set.
REQ-019 Saturate mode, cnt = 2^N-1 with tick: counter SHALL hold 2^N-1 and of[i] SHALL be set.
REQ-020 of[i] SHALL stay set until clr[i], an accepted snapshot, or reset.
REQ-021 A sat_mode change SHALL take effect on the next edge and SHALL NOT alter stored values.
REQ-022 clr[i] SHALL override a same-cycle tick[i]: counter 0, of[i] 0.
REQ-023 snap_req SHALL be accepted when snap_valid=0 or snap_ack=1 in the same cycle.
REQ-024 On accept, shadow i SHALL capture the post-tick value of the live counter, meaning the value per REQ-017..019 including that cycle's tick.
REQ-025 On accept, shadow of[i] SHALL capture the post-tick flag, meaning of[i] OR the overflow event of that cycle.
REQ-026 On accept, every live counter and of[i] SHALL restart at 0 on the next cycle, so no tick is lost or double-counted.
REQ-027 On accept, snap_valid SHALL be 1 on the next cycle.
REQ-028 clr[i] in an accept cycle SHALL force shadow i to 0 and shadow of[i] to 0.
REQ-029 snap_ack with no accepted snap_req SHALL drop snap_valid to 0 on the next cycle; shadows SHALL hold.
REQ-030 snap_req when snap_valid=1 and snap_ack=0 SHALL be ignored, and snap_drop SHALL pulse on the next cycle.
REQ-031 Shadows SHALL remain unchanged while snap_valid=1.
REQ-032 rd_count and rd_of SHALL reflect rd_sel with a latency of 1 cycle.
REQ-033 rd_sel >= C SHALL return rd_count=0 and rd_of=0.

Reset
REQ-034 While reset_n=0, all live counters, shadows, of, live_of, snap_valid, snap_drop, rd_count and rd_of SHALL be 0.
REQ-035 Reset mid-snapshot SHALL discard the snapshot; the first accepted snap_req after release SHALL behave per REQ-023..028.

Structure
REQ-036 A shared package SHALL hold the mode encodings SAT_MODE=1 and WRAP_MODE=0.
REQ-037 A sub-module tick_channel (one live counter, its overflow flag and shadow) SHALL be instantiated C times.
REQ-038 Snapshot control and the read mux SHALL reside in multi_tick_counter.

Verification
REQ-039 N=4, wrap mode, 17 ticks on channel 0 -> live count 1, live_of[0]=1, other channels 0.
REQ-040 N=4, saturate mode, 20 ticks on channel 1 -> count holds 15, live_of[1]=1.
REQ-041 Ch2 at 5 with tick high in snap_req cycle -> shadow 6, live 0 next cycle, snap_valid=1 next cycle, rd_sel=2 gives rd_count=6 one cycle later.
REQ-042 Second snap_req while snap_valid=1 with no ack -> snap_drop pulse, shadows unchanged; snap_req together with snap_ack -> accepted, new data captured.
REQ-043 clr[3] together with tick[3] at count 9 -> count 0, of[3]=0; clr[3] in an accept cycle -> shadow 3 = 0.
REQ-044 reset_n low while snap_valid=1 and counts nonzero -> all outputs 0 immediately, with no clock edge.
